// File: rtl/md_sched_if.sv
// md_sched_if
// Engine-side bus between the mult/div issue controller and the external
// iterative mult/div engine.
//   eng_start  one-cycle start pulse, controller -> engine
//   eng_op     [1] = 1 div / 0 mult, [0] = 1 signed; held while the op runs
//   eng_a      latched rs operand, held while the op runs
//   eng_b      latched rt operand, held while the op runs
//   eng_hi     engine HI result, engine -> controller
//   eng_lo     engine LO result, engine -> controller
// The master modport is the controller side; slave is the engine side.
interface md_sched_if;
   logic        eng_start;
   logic [1:0]  eng_op;
   logic [31:0] eng_a;
   logic [31:0] eng_b;
   logic [31:0] eng_hi;
   logic [31:0] eng_lo;

   modport master (
      output eng_start,
      output eng_op,
      output eng_a,
      output eng_b,
      input  eng_hi,
      input  eng_lo
   );

   modport slave (
      input  eng_start,
      input  eng_op,
      input  eng_a,
      input  eng_b,
      output eng_hi,
      output eng_lo
   );
endinterface

// File: rtl/md_sched.sv
// md_sched
// Issue and commit controller for the mult/div unit in the E stage of the
// pipelined MIPS core. Decodes the E-stage MD opcode, issues mult/div ops to
// an external iterative engine, holds the operands while the engine runs,
// counts the fixed latency and then commits the engine result into HI/LO.
// Also serves mfhi/mflo reads and stalls MD-class instructions in D while
// the unit is occupied.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   op_d       MD opcode of the D-stage instruction (0 = none)
//   op_e       MD opcode of the E-stage instruction: 0 none, 1 mtlo, 2 mthi,
//              3 divu, 4 div, 5 multu, 6 mult, 7 mflo, 8 mfhi (9..15 = none)
//   flush_e    E-stage instruction is cancelled this cycle
//   numa/numb  rs/rt operands in E
//   eng        engine bus (start pulse, op, operands out; results in)
//   busy       an op is running in the engine
//   xstall     stall the D stage
//   xaluout    mfhi/mflo read data
//   div0       one-cycle pulse: div/divu issued with numb == 0
//   proto_err  one-cycle pulse: MD-class op arrived in E while busy
module md_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        op_d,
   input  logic [3:0]        op_e,
   input  logic              flush_e,
   input  logic [31:0]       numa,
   input  logic [31:0]       numb,
   md_sched_if.master        eng,
   output logic              busy,
   output logic              xstall,
   output logic [31:0]       xaluout,
   output logic              div0,
   output logic              proto_err
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic [31:0]       hi;
   logic [31:0]       hi_next;
   logic [31:0]       lo;
   logic [31:0]       lo_next;
   logic [31:0]       a_q;
   logic [31:0]       a_next;
   logic [31:0]       b_q;
   logic [31:0]       b_next;
   logic [1:0]        op_q;
   logic [1:0]        op_next;
   logic              start_q;
   logic              start_next;
   logic              div0_q;
   logic              div0_next;
   logic              perr_q;
   logic              perr_next;

   logic              live_e;
   logic              start_e;
   logic              md_e;
   logic              is_div_e;
   logic              is_signed_e;
   logic              is_mthi_e;
   logic              is_mtlo_e;

   // Opcode decode for the E-stage instruction. Opcodes 9..15 fall outside
   // every range below and therefore behave exactly like "none". A flushed
   // instruction may still be decoded, but it can neither issue nor write
   // HI/LO, so flush_e is folded into the qualifying terms here.
   always_comb begin
      live_e      = !flush_e;
      start_e     = (op_e >= 4'd3) && (op_e <= 4'd6) && live_e;
      md_e        = (op_e >= 4'd1) && (op_e <= 4'd6) && live_e;
      is_div_e    = (op_e == 4'd3) || (op_e == 4'd4);
      is_signed_e = (op_e == 4'd4) || (op_e == 4'd6);
      is_mthi_e   = (op_e == 4'd2) && live_e;
      is_mtlo_e   = (op_e == 4'd1) && live_e;
   end

   // Next-state and datapath logic. In IDLE a start either issues (latching
   // the operands and loading the latency counter) or, for a divide by zero,
   // is dropped with a div0 pulse. In RUN the counter walks down to 1 and the
   // engine result is committed on that edge, so busy lasts exactly LAT
   // cycles and the new HI/LO is visible on the first IDLE cycle. Any MD op
   // that shows up while running is dropped and flagged via proto_err.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      hi_next    = hi;
      lo_next    = lo;
      a_next     = a_q;
      b_next     = b_q;
      op_next    = op_q;
      start_next = 1'b0;
      div0_next  = 1'b0;
      perr_next  = 1'b0;

      case (state)
         IDLE: begin
            if (start_e) begin
               if (is_div_e && (numb == 32'd0)) begin
                  div0_next = 1'b1;
               end else begin
                  a_next     = numa;
                  b_next     = numb;
                  op_next    = {is_div_e, is_signed_e};
                  cnt_next   = is_div_e ? DIV_CNT : MULT_CNT;
                  start_next = 1'b1;
                  state_next = RUN;
               end
            end else if (is_mthi_e) begin
               hi_next = numa;
            end else if (is_mtlo_e) begin
               lo_next = numa;
            end
         end

         RUN: begin
            if (md_e) begin
               perr_next = 1'b1;
            end
            if (cnt == CNT_ONE) begin
               hi_next    = eng.eng_hi;
               lo_next    = eng.eng_lo;
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CNT_ONE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register. Reset discards any in-flight op along with HI/LO and
   // the latched engine operands.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         start_q <= 1'b0;
         div0_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         hi      <= hi_next;
         lo      <= lo_next;
         a_q     <= a_next;
         b_q     <= b_next;
         op_q    <= op_next;
         start_q <= start_next;
         div0_q  <= div0_next;
         perr_q  <= perr_next;
      end
   end

   // Engine bus and status outputs. xstall includes start_e so that an MD
   // op sitting in D behind an op issuing this cycle is held until the
   // first IDLE cycle. xaluout reads committed HI/LO only; while an op is
   // running the D-stage stall keeps mfhi/mflo from reaching E.
   assign eng.eng_start = start_q;
   assign eng.eng_op    = op_q;
   assign eng.eng_a     = a_q;
   assign eng.eng_b     = b_q;

   assign busy      = (state == RUN);
   assign xstall    = (op_d != 4'd0) && (busy || start_e);
   assign xaluout   = (op_e == 4'd8) ? hi :
                      (op_e == 4'd7) ? lo : 32'd0;
   assign div0      = div0_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched
// Testbench for md_sched: a behavioural engine answers the issue bus, a
// reference model of the unit predicts every output cycle by cycle, and a
// monitor compares the DUT against the queued predictions.
module tb_md_sched;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   typedef struct {
      logic        busy;
      logic        xstall;
      logic        div0;
      logic        proto;
      logic        start;
      logic [31:0] xalu;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  op_d;
   logic [3:0]  op_e;
   logic        flush_e;
   logic [31:0] numa;
   logic [31:0] numb;
   logic        busy;
   logic        xstall;
   logic [31:0] xaluout;
   logic        div0;
   logic        proto_err;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   // Reference model state: committed HI/LO, cycles left on the running op,
   // the result that op will commit, and the registered outputs expected
   // in the coming cycle.
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   int          m_remain = 0;
   logic [31:0] m_pend_hi = '0;
   logic [31:0] m_pend_lo = '0;
   logic        m_div0 = 1'b0;
   logic        m_proto = 1'b0;
   logic        m_start = 1'b0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic [1:0]  m_op = '0;

   int eng_k = 0;

   md_sched_if bus ();

   md_sched #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op_d      (op_d),
      .op_e      (op_e),
      .flush_e   (flush_e),
      .numa      (numa),
      .numb      (numb),
      .eng       (bus.master),
      .busy      (busy),
      .xstall    (xstall),
      .xaluout   (xaluout),
      .div0      (div0),
      .proto_err (proto_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // MIPS mult/div semantics: {hi, lo} = 64-bit product, or hi = remainder
   // and lo = quotient (truncating toward zero for the signed forms).
   function automatic logic [63:0] mdCompute(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] r;
      case (op)
         2'b00:   r = {32'd0, a} * {32'd0, b};
         2'b01:   r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         2'b10:   r = {a % b, a / b};
         default: r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      endcase
      return r;
   endfunction

   // Behavioural engine: it notices the start pulse, counts the op's
   // latency and presents the true result only in the last running cycle,
   // computed from the operands the DUT is holding at that moment. All
   // other cycles carry random garbage, so an early or late commit, or
   // operands that drift mid-op, show up as wrong HI/LO.
   always @(negedge clk) begin
      int lat;
      lat = bus.eng_op[1] ? DIV_LAT : MULT_LAT;
      if (bus.eng_start === 1'b1) begin
         eng_k = 1;
      end else if (eng_k > 0) begin
         eng_k++;
      end
      if ((eng_k > 0) && (eng_k == lat)) begin
         {bus.eng_hi, bus.eng_lo} = mdCompute(bus.eng_op, bus.eng_a, bus.eng_b);
         eng_k = 0;
      end else begin
         bus.eng_hi = $urandom;
         bus.eng_lo = $urandom;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Drives one cycle of inputs, queues the outputs the model expects for
   // that cycle, then advances the model across the next clock edge.
   task automatic applyStimulus(input logic [3:0] d, input logic [3:0] e,
                                input logic fl, input logic [31:0] a,
                                input logic [31:0] b, input logic rst);
      exp_t ex;
      logic start_e;
      logic md_e;
      logic is_div;
      reset   = rst;
      op_d    = d;
      op_e    = e;
      flush_e = fl;
      numa    = a;
      numb    = b;

      start_e = (e >= 4'd3) && (e <= 4'd6) && !fl;
      md_e    = (e >= 4'd1) && (e <= 4'd6) && !fl;
      is_div  = (e == 4'd3) || (e == 4'd4);

      ex.busy   = (m_remain > 0);
      ex.xstall = (d != 4'd0) && (ex.busy || start_e);
      ex.xalu   = (e == 4'd8) ? m_hi : (e == 4'd7) ? m_lo : 32'd0;
      ex.div0   = m_div0;
      ex.proto  = m_proto;
      ex.start  = m_start;
      ex.a      = m_a;
      ex.b      = m_b;
      ex.op     = m_op;
      exp_q.push_back(ex);

      m_div0  = 1'b0;
      m_proto = 1'b0;
      m_start = 1'b0;
      if (rst) begin
         m_hi     = '0;
         m_lo     = '0;
         m_remain = 0;
         m_a      = '0;
         m_b      = '0;
         m_op     = '0;
      end else if (m_remain > 0) begin
         if (md_e) m_proto = 1'b1;
         m_remain--;
         if (m_remain == 0) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
         end
      end else if (start_e) begin
         if (is_div && (b == 32'd0)) begin
            m_div0 = 1'b1;
         end else begin
            m_op = {is_div, (e == 4'd4) || (e == 4'd6)};
            m_a  = a;
            m_b  = b;
            {m_pend_hi, m_pend_lo} = mdCompute(m_op, a, b);
            m_remain = is_div ? DIV_LAT : MULT_LAT;
            m_start  = 1'b1;
         end
      end else if ((e == 4'd2) && !fl) begin
         m_hi = a;
      end else if ((e == 4'd1) && !fl) begin
         m_lo = a;
      end

      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n, input logic [3:0] d);
      for (int i = 0; i < n; i++) applyStimulus(d, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   // Monitor: halfway through each cycle, pop the prediction for that cycle
   // and compare every DUT output against it.
   always @(negedge clk) begin
      exp_t ex;
      if (exp_q.size() > 0) begin
         ex = exp_q.pop_front();
         checkOutput("busy",      32'(busy),          32'(ex.busy));
         checkOutput("xstall",    32'(xstall),        32'(ex.xstall));
         checkOutput("xaluout",   xaluout,            ex.xalu);
         checkOutput("div0",      32'(div0),          32'(ex.div0));
         checkOutput("proto_err", 32'(proto_err),     32'(ex.proto));
         checkOutput("eng_start", 32'(bus.eng_start), 32'(ex.start));
         checkOutput("eng_a",     bus.eng_a,          ex.a);
         checkOutput("eng_b",     bus.eng_b,          ex.b);
         checkOutput("eng_op",    32'(bus.eng_op),    32'(ex.op));
      end
   end

   // Directed scenarios first, then a long randomized run.
   initial begin
      reset   = 1'b1;
      op_d    = '0;
      op_e    = '0;
      flush_e = 1'b0;
      numa    = '0;
      numb    = '0;
      @(posedge clk);
      @(posedge clk);
      #1;

      $display("[TB] reset state");
      idleCycles(2, 4'd0);

      $display("[TB] mult -3 * 7");
      applyStimulus(4'd0, 4'd6, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0);
      idleCycles(MULT_LAT, 4'd0);
      applyStimulus(4'd0, 4'd8, 1'b0, 32'd0, 32'd0, 1'b0);
      applyStimulus(4'd0, 4'd7, 1'b0, 32'd0, 32'd0, 1'b0);

      $display("[TB] div 7 / 2 with mfhi held in D");
      applyStimulus(4'd8, 4'd4, 1'b0, 32'd7, 32'd2, 1'b0);
      idleCycles(DIV_LAT, 4'd8);
      applyStimulus(4'd7, 4'd8, 1'b0, 32'd0, 32'd0, 1'b0);
      applyStimulus(4'd0, 4'd7, 1'b0, 32'd0, 32'd0, 1'b0);

      $display("[TB] divu by zero after mthi 0x55");
      applyStimulus(4'd0, 4'd2, 1'b0, 32'h55, 32'd0, 1'b0);
      applyStimulus(4'd0, 4'd3, 1'b0, 32'd9, 32'd0, 1'b0);
      idleCycles(3, 4'd0);
      applyStimulus(4'd0, 4'd8, 1'b0, 32'd0, 32'd0, 1'b0);

      $display("[TB] flushed mult and mtlo");
      applyStimulus(4'd0, 4'd6, 1'b1, 32'd4, 32'd5, 1'b0);
      idleCycles(2, 4'd0);
      applyStimulus(4'd0, 4'd1, 1'b1, 32'hAB, 32'd0, 1'b0);
      applyStimulus(4'd0, 4'd7, 1'b0, 32'd0, 32'd0, 1'b0);

      $display("[TB] reset in cycle 3 of a div");
      applyStimulus(4'd0, 4'd4, 1'b0, 32'd100, 32'd7, 1'b0);
      idleCycles(2, 4'd0);
      applyStimulus(4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      idleCycles(DIV_LAT + 2, 4'd8);
      applyStimulus(4'd0, 4'd8, 1'b0, 32'd0, 32'd0, 1'b0);
      applyStimulus(4'd0, 4'd7, 1'b0, 32'd0, 32'd0, 1'b0);

      $display("[TB] mtlo while busy");
      applyStimulus(4'd0, 4'd5, 1'b0, 32'd5, 32'd6, 1'b0);
      applyStimulus(4'd0, 4'd1, 1'b0, 32'hAB, 32'd0, 1'b0);
      idleCycles(MULT_LAT, 4'd0);
      applyStimulus(4'd0, 4'd7, 1'b0, 32'd0, 32'd0, 1'b0);

      $display("[TB] randomized run");
      for (int i = 0; i < 3000; i++) begin
         logic [3:0]  d;
         logic [3:0]  e;
         logic        fl;
         logic [31:0] a;
         logic [31:0] b;
         logic        rst;
         d   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         e   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         fl  = ($urandom_range(0, 7) == 0);
         a   = $urandom;
         b   = ($urandom_range(0, 5) == 0) ? 32'd0 :
               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
         rst = ($urandom_range(0, 199) == 0);
         applyStimulus(d, e, fl, a, b, rst);
      end
      idleCycles(DIV_LAT + 2, 4'd0);

      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
